// File: rtl/ttn_scale_mon.sv
// ttn_scale_mon: measures the high/low times of a divided clock (cin) in clk cycles,
// checks them against the expected division, and tracks lock. Define TTN_SCALE_MON_TIMEOUT_EN for stuck detection.
module ttn_scale_mon #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cin,
    input  logic [CNT_W-1:0] exp_high,
    input  logic [CNT_W-1:0] exp_low,
    input  logic [7:0]       lock_count,
    output logic [CNT_W-1:0] meas_first,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (CNT_W < 2 || TIMEOUT < 1) begin : g_param_check
        $error("ttn_scale_mon: CNT_W must be >= 2 and TIMEOUT >= 1");
    end

`ifdef TTN_SCALE_MON_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        HIGH       = 3'd2,
        LOW        = 3'd3,
        STUCK      = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic             cin_q;
    logic             rise, fall;
    logic [CNT_W-1:0] first_cnt_q, first_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [7:0]       lock_target;
    logic [CNT_W-1:0] meas_first_d, meas_high_d, meas_low_d;
    logic             meas_valid_d;
    logic             mismatch_d;
    logic             count_period;

`ifdef TTN_SCALE_MON_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             stuck_d, stuck_level_d;
    logic             skip_q, skip_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // High may be one short of nominal (odd divide) but the full period must be exact.
    function automatic logic period_match(input logic [CNT_W-1:0] hi,
                                          input logic [CNT_W-1:0] lo,
                                          input logic [CNT_W-1:0] eh,
                                          input logic [CNT_W-1:0] el);
        logic [CNT_W:0] sum_meas;
        logic [CNT_W:0] sum_exp;
        sum_meas = {1'b0, hi} + {1'b0, lo};
        sum_exp  = {1'b0, eh} + {1'b0, el};
        return ((hi == eh) || (hi == eh - ONE)) && (sum_meas == sum_exp);
    endfunction

    assign rise        = cin & ~cin_q;
    assign fall        = ~cin & cin_q;
    assign lock_target = (lock_count == 8'd0) ? 8'd1 : lock_count;
    assign locked      = (match_cnt_q == lock_target);

`ifdef TTN_SCALE_MON_TIMEOUT_EN
    assign count_period = ~skip_q;
`else
    assign count_period = 1'b1;
    assign stuck        = 1'b0;
    assign stuck_level  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        first_cnt_d  = first_cnt_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        match_cnt_d  = match_cnt_q;
        meas_first_d = meas_first;
        meas_high_d  = meas_high;
        meas_low_d   = meas_low;
        meas_valid_d = 1'b0;
        mismatch_d   = mismatch;
`ifdef TTN_SCALE_MON_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
        stuck_d       = stuck;
        stuck_level_d = stuck_level;
        skip_d        = skip_q;
`endif

        if (!enable) begin
            state_d     = IDLE;
            match_cnt_d = '0;
            mismatch_d  = 1'b0;
`ifdef TTN_SCALE_MON_TIMEOUT_EN
            idle_cnt_d    = '0;
            stuck_d       = 1'b0;
            stuck_level_d = 1'b0;
            skip_d        = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = WAIT_FIRST;
                    first_cnt_d = ONE;
                end
                WAIT_FIRST: begin
                    first_cnt_d = sat_inc(first_cnt_q);
                    if (rise) begin
                        meas_first_d = first_cnt_q;
                        high_cnt_d   = ONE;
                        state_d      = HIGH;
                    end
                end
                HIGH: begin
                    high_cnt_d = sat_inc(high_cnt_q);
                    if (fall) begin
                        meas_high_d = high_cnt_q;
                        low_cnt_d   = ONE;
                        state_d     = LOW;
                    end
                end
                LOW: begin
                    low_cnt_d = sat_inc(low_cnt_q);
                    if (rise) begin
                        meas_low_d = low_cnt_q;
                        high_cnt_d = ONE;
                        state_d    = HIGH;
`ifdef TTN_SCALE_MON_TIMEOUT_EN
                        skip_d     = 1'b0;
`endif
                        if (count_period) begin
                            meas_valid_d = 1'b1;
                            if (period_match(meas_high, low_cnt_q, exp_high, exp_low)) begin
                                match_cnt_d = (match_cnt_q >= lock_target) ? lock_target
                                                                           : match_cnt_q + 8'd1;
                            end else begin
                                match_cnt_d = '0;
                                mismatch_d  = 1'b1;
                            end
                        end
                    end
                end
`ifdef TTN_SCALE_MON_TIMEOUT_EN
                // Leaving via a fall means the next rise closes a period that spans the stall.
                STUCK: begin
                    if (rise) begin
                        state_d       = HIGH;
                        high_cnt_d    = ONE;
                        stuck_d       = 1'b0;
                        stuck_level_d = 1'b0;
                        idle_cnt_d    = '0;
                    end else if (fall) begin
                        state_d       = LOW;
                        low_cnt_d     = ONE;
                        stuck_d       = 1'b0;
                        stuck_level_d = 1'b0;
                        idle_cnt_d    = '0;
                        skip_d        = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase

`ifdef TTN_SCALE_MON_TIMEOUT_EN
            if (state_q == WAIT_FIRST || state_q == HIGH || state_q == LOW) begin
                if (rise || fall) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = sat_inc(idle_cnt_q);
                    if (idle_cnt_d >= TIMEOUT_LIM) begin
                        state_d       = STUCK;
                        stuck_d       = 1'b1;
                        stuck_level_d = cin_q;
                        match_cnt_d   = '0;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cin_q       <= 1'b0;
            first_cnt_q <= '0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            match_cnt_q <= '0;
            meas_first  <= '0;
            meas_high   <= '0;
            meas_low    <= '0;
            meas_valid  <= 1'b0;
            mismatch    <= 1'b0;
`ifdef TTN_SCALE_MON_TIMEOUT_EN
            idle_cnt_q  <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            skip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cin_q       <= cin;
            first_cnt_q <= first_cnt_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            match_cnt_q <= match_cnt_d;
            meas_first  <= meas_first_d;
            meas_high   <= meas_high_d;
            meas_low    <= meas_low_d;
            meas_valid  <= meas_valid_d;
            mismatch    <= mismatch_d;
`ifdef TTN_SCALE_MON_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
            stuck       <= stuck_d;
            stuck_level <= stuck_level_d;
            skip_q      <= skip_d;
`endif
        end
    end

endmodule

// File: tb/tb_ttn_scale_mon.sv
// tb_ttn_scale_mon: randomized and directed checks of ttn_scale_mon against a period-level
// reference model built from the generated cin waveform.
module tb_ttn_scale_mon;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             cin;
    logic [CNT_W-1:0] exp_high;
    logic [CNT_W-1:0] exp_low;
    logic [7:0]       lock_count;
    logic [CNT_W-1:0] meas_first;
    logic [CNT_W-1:0] meas_high;
    logic [CNT_W-1:0] meas_low;
    logic             meas_valid;
    logic             locked;
    logic             mismatch;
    logic             stuck;
    logic             stuck_level;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: last reported measurements and the current matched-period streak.
    int m_first  = 0;
    int m_high   = 0;
    int m_low    = 0;
    int m_streak = 0;
    int m_lce    = 1;
    bit m_valid  = 1'b0;
    bit m_mism   = 1'b0;

    int ph[32];
    int pl[32];

    ttn_scale_mon #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cin         (cin),
        .exp_high    (exp_high),
        .exp_low     (exp_low),
        .lock_count  (lock_count),
        .meas_first  (meas_first),
        .meas_high   (meas_high),
        .meas_low    (meas_low),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .mismatch    (mismatch),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick(input logic en, input logic c);
        enable = en;
        cin    = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".valid"},    64'(meas_valid), 64'(m_valid));
        check_eq({tag, ".first"},    64'(meas_first), 64'(m_first));
        check_eq({tag, ".high"},     64'(meas_high),  64'(m_high));
        check_eq({tag, ".low"},      64'(meas_low),   64'(m_low));
        check_eq({tag, ".locked"},   64'(locked),     64'(m_streak >= m_lce));
        check_eq({tag, ".mismatch"}, 64'(mismatch),   64'(m_mism));
        check_eq({tag, ".stuck"},    64'(stuck),      64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".first"},  64'(meas_first),  64'(0));
        check_eq({tag, ".high"},   64'(meas_high),   64'(0));
        check_eq({tag, ".low"},    64'(meas_low),    64'(0));
        check_eq({tag, ".valid"},  64'(meas_valid),  64'(0));
        check_eq({tag, ".locked"}, 64'(locked),      64'(0));
        check_eq({tag, ".mism"},   64'(mismatch),    64'(0));
        check_eq({tag, ".stuck"},  64'(stuck),       64'(0));
        check_eq({tag, ".level"},  64'(stuck_level), 64'(0));
    endtask

    // One measurement run: lead-in low of l0 cycles, np periods from ph/pl, a closing rise,
    // then enable dropped drop_back cycles before the end of the waveform.
    task automatic do_run(input string name, input int l0, input int np, input int eh,
                          input int el, input int lc, input int drop_back);
        bit stim[$];
        int hi_ev[$];
        int pe_ev[$];
        int t;
        int tlen;
        int drop;
        exp_high   = CNT_W'(eh);
        exp_low    = CNT_W'(el);
        lock_count = 8'(lc);
        m_lce      = (lc == 0) ? 1 : lc;
        for (int i = 0; i < l0; i++) stim.push_back(1'b0);
        for (int i = 0; i < np; i++) begin
            for (int j = 0; j < ph[i]; j++) stim.push_back(1'b1);
            for (int j = 0; j < pl[i]; j++) stim.push_back(1'b0);
        end
        stim.push_back(1'b1);
        tlen = stim.size();
        for (int k = 0; k < tlen; k++) begin
            hi_ev.push_back(-1);
            pe_ev.push_back(-1);
        end
        t = l0;
        for (int i = 0; i < np; i++) begin
            hi_ev[t + ph[i]] = ph[i];
            t = t + ph[i] + pl[i];
            pe_ev[t] = i;
        end
        drop = tlen - drop_back;
        if (drop < l0 + 1) drop = l0 + 1;

        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0);
            m_valid  = 1'b0;
            m_streak = 0;
            m_mism   = 1'b0;
            check_model({name, ".idle"});
        end
        for (int k = 0; k <= drop + 1; k++) begin
            tick(k < drop, (k < tlen) ? stim[k] : 1'b0);
            m_valid = 1'b0;
            if (k >= drop) begin
                m_streak = 0;
                m_mism   = 1'b0;
            end else begin
                if (k == l0) m_first = l0;
                if (hi_ev[k] >= 0) m_high = hi_ev[k];
                if (pe_ev[k] >= 0) begin
                    int h;
                    int l;
                    bit ok;
                    h = ph[pe_ev[k]];
                    l = pl[pe_ev[k]];
                    m_low   = l;
                    m_valid = 1'b1;
                    ok = ((h == eh) || (h == eh - 1)) && (h + l == eh + el);
                    if (ok) begin
                        m_streak++;
                    end else begin
                        m_streak = 0;
                        m_mism   = 1'b1;
                    end
                end
            end
            check_model(name);
        end
    endtask

    task automatic fill(input int n, input int h, input int l);
        for (int i = 0; i < n; i++) begin
            ph[i] = h;
            pl[i] = l;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        cin        = 1'b0;
        exp_high   = '0;
        exp_low    = '0;
        lock_count = '0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_all_zero("reset");
        reset_n = 1'b1;

`ifdef TTN_SCALE_MON_TIMEOUT_EN
        exp_high   = CNT_W'(3);
        exp_low    = CNT_W'(3);
        lock_count = 8'd1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int k = 0; k <= 86; k++) begin
            logic c;
            c = ((k >= 1 && k <= 3) || (k >= 7 && k <= 9) || (k >= 80 && k <= 82) || k == 86);
            tick(1'b1, c);
            if (k == 73) begin
                check_eq("stk.before",        64'(stuck),  64'(0));
                check_eq("stk.before_locked", 64'(locked), 64'(1));
            end
            if (k == 74) begin
                check_eq("stk.set",    64'(stuck),       64'(1));
                check_eq("stk.level",  64'(stuck_level), 64'(0));
                check_eq("stk.locked", 64'(locked),      64'(0));
            end
            if (k == 80) begin
                check_eq("stk.exit",       64'(stuck),      64'(0));
                check_eq("stk.exit_valid", 64'(meas_valid), 64'(0));
            end
            if (k == 86) begin
                check_eq("stk.relock_valid", 64'(meas_valid), 64'(1));
                check_eq("stk.relock",       64'(locked),     64'(1));
            end
        end
        tick(1'b0, 1'b0);
`endif

        // Lock on one 3/3 period, then pull reset in the middle of the following high phase.
        exp_high   = CNT_W'(3);
        exp_low    = CNT_W'(3);
        lock_count = 8'd1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            tick(1'b1, (k >= 1 && k <= 3) || k >= 7);
            if (k == 1) check_eq("rst.first", 64'(meas_first), 64'(1));
            if (k == 7) begin
                check_eq("rst.valid",  64'(meas_valid), 64'(1));
                check_eq("rst.locked", 64'(locked),     64'(1));
            end
        end
        check_eq("rst.pre_high", 64'(meas_high), 64'(3));
        check_eq("rst.pre_low",  64'(meas_low),  64'(3));
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            tick(a < 7, (a == 0) || (a >= 4 && a <= 6));
            check_eq("rst.post_valid",  64'(meas_valid), 64'(0));
            check_eq("rst.post_first",  64'(meas_first), 64'((a >= 4) ? 4 : 0));
            check_eq("rst.post_high",   64'(meas_high),  64'(0));
            check_eq("rst.post_locked", 64'(locked),     64'(0));
        end
        m_first  = 4;
        m_high   = 0;
        m_low    = 0;
        m_streak = 0;
        m_mism   = 1'b0;

        fill(6, 3, 3);
        do_run("even", 2, 6, 3, 3, 4, 0);
        fill(5, 2, 3);
        do_run("odd", 1, 5, 3, 2, 3, 0);
        fill(3, 4, 2);
        do_run("duty", 3, 3, 3, 3, 2, 0);
        fill(4, 3, 3);
        ph[1] = 4;
        pl[1] = 2;
        do_run("drop", 2, 4, 3, 3, 1, 0);
        fill(3, 2, 2);
        do_run("prio", 1, 3, 2, 2, 2, 1);
        fill(3, 3, 1);
        do_run("lc0", 1, 3, 3, 1, 0, 0);

        for (int r = 0; r < 30; r++) begin
            int l0;
            int np;
            int eh;
            int el;
            int lc;
            l0 = int'($urandom_range(1, 4));
            np = int'($urandom_range(1, 8));
            eh = int'($urandom_range(1, 5));
            el = int'($urandom_range(1, 5));
            lc = int'($urandom_range(0, 4));
            for (int i = 0; i < np; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    ph[i] = (eh > 1 && $urandom_range(0, 1) == 1) ? eh - 1 : eh;
                    pl[i] = eh + el - ph[i];
                end else begin
                    ph[i] = int'($urandom_range(1, 6));
                    pl[i] = int'($urandom_range(1, 6));
                end
            end
            do_run("rand", l0, np, eh, el, lc, int'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
